// File: rtl/mdu_sched.sv
// mdu_sched: HI/LO multiply/divide scheduler for an in-order pipeline.
// Computes mult/div results when the operation is accepted, holds them in
// pending registers for a fixed latency, then commits them to HI/LO.
// mthi/mtlo write HI/LO directly. The D-stage stall is produced combinationally.
module mdu_sched #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        hilo_sel,
    input  logic        md_in_D,
    output logic        busy,
    output logic        stall_D,
    output logic [31:0] rd_data
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int CYC_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(CYC_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [31:0]        pend_hi_q;
    logic [31:0]        pend_lo_q;
    logic               pend_wr_q;

    // Datapath signals evaluated from the operands presented with start.
    logic               op_signed;
    logic [63:0]        mul_a;
    logic [63:0]        mul_b;
    logic [63:0]        product;
    logic               rs_neg;
    logic               rt_neg;
    logic [31:0]        rs_mag;
    logic [31:0]        rt_mag;
    logic [31:0]        divisor_safe;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;
    logic [31:0]        quot;
    logic [31:0]        rem;
    logic               div_by_zero;
    logic               long_op;

    // Operand conditioning, product and signed/unsigned division results.
    always_comb begin
        op_signed = (md_op == OP_MULT) || (md_op == OP_DIV);

        // Sign- or zero-extend to 64 bits; the low 64 bits of the product of
        // the extended operands are the exact 32x32 result for either case.
        mul_a   = {{32{op_signed & rs_data[31]}}, rs_data};
        mul_b   = {{32{op_signed & rt_data[31]}}, rt_data};
        product = mul_a * mul_b;

        // Signed division is done on magnitudes, then the signs are restored:
        // the quotient truncates toward zero and the remainder follows the
        // dividend. 0x80000000 / -1 falls out naturally as 0x80000000 r 0.
        rs_neg       = op_signed & rs_data[31];
        rt_neg       = op_signed & rt_data[31];
        rs_mag       = rs_neg ? (~rs_data + 32'd1) : rs_data;
        rt_mag       = rt_neg ? (~rt_data + 32'd1) : rt_data;
        div_by_zero  = (rt_data == 32'd0);
        // Keep the divider away from a zero divisor; the result is discarded.
        divisor_safe = div_by_zero ? 32'd1 : rt_mag;
        q_mag        = rs_mag / divisor_safe;
        r_mag        = rs_mag % divisor_safe;
        quot         = (rs_neg ^ rt_neg) ? (~q_mag + 32'd1) : q_mag;
        rem          = rs_neg ? (~r_mag + 32'd1) : r_mag;

        // Only mult/multu/div/divu (md_op 0..3) start a long operation.
        long_op      = start & ~md_op[2];
    end

    // Scheduler FSM: accepts operations in IDLE, counts down the latency and
    // commits pending HI/LO on the final busy cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (md_op)
                            OP_MULT, OP_MULTU: begin
                                pend_hi_q <= product[63:32];
                                pend_lo_q <= product[31:0];
                                pend_wr_q <= 1'b1;
                                cnt_q     <= CNT_W'(MULT_CYC);
                                busy_q    <= 1'b1;
                                state_q   <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_hi_q <= rem;
                                pend_lo_q <= quot;
                                // A zero divisor still occupies the unit for
                                // the full latency but commits nothing.
                                pend_wr_q <= ~div_by_zero;
                                cnt_q     <= CNT_W'(DIV_CYC);
                                busy_q    <= 1'b1;
                                state_q   <= S_DIV;
                            end
                            OP_MTHI: hi_q <= rs_data;
                            OP_MTLO: lo_q <= rs_data;
                            default: ; // reserved encodings do nothing
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    // start is ignored here, including mthi/mtlo.
                    if (cnt_q <= CNT_W'(1)) begin
                        if (pend_wr_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        pend_wr_q <= 1'b0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode: stall while busy or while a long op is being issued.
    always_comb begin
        busy    = busy_q;
        stall_D = md_in_D & (busy_q | long_op);
        rd_data = hilo_sel ? hi_q : lo_q;
    end

endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: directed table-driven bench for mdu_sched plus hand-written
// sequences for reset mid-operation, back-to-back issue and mthi while busy.
`timescale 1ns/1ps
module tb_mdu_sched;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hilo_sel;
    logic        md_in_D;
    logic        busy;
    logic        stall_D;
    logic [31:0] rd_data;

    int tests;
    int failures;

    mdu_sched #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .hilo_sel (hilo_sel),
        .md_in_D  (md_in_D),
        .busy     (busy),
        .stall_D  (stall_D),
        .rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        hilo_sel = 1'b1;
        #1;
        hi = rd_data;
        hilo_sel = 1'b0;
        #1;
        lo = rd_data;
    endtask

    // Present one operation for a single clock; returns at posedge + 1.
    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        start   = 1'b1;
        md_op   = op;
        rs_data = rs;
        rt_data = rt;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count cycles until busy drops, sampling at posedge + 1.
    task automatic wait_idle(input string name, output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 64) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        if (cnt >= 64) begin
            failures++;
            tests++;
            $display("FAIL %s_timeout: got busy stuck, expected release within 64 cycles", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] h;
        logic [31:0] l;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        int          cnt;

        tests    = 0;
        failures = 0;

        vecs[0]  = '{"mult_neg1x2",    3'd0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1]  = '{"multu_ffx2",     3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{"div_m7_2",       3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{"divu_7_0",       3'd3, 32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4]  = '{"div_min_m1",     3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{"mtlo_1234",      3'd5, 32'h00001234, 32'd0,        32'h00000000, 32'h00001234, 0};
        vecs[6]  = '{"mthi_abcd",      3'd4, 32'hABCD0000, 32'd0,        32'hABCD0000, 32'h00001234, 0};
        vecs[7]  = '{"rsvd6",          3'd6, 32'h00000005, 32'd9,        32'hABCD0000, 32'h00001234, 0};
        vecs[8]  = '{"divu_100_7",     3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
        vecs[9]  = '{"mult_min_min",   3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[10] = '{"div_7_m2",       3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[11] = '{"mult_3_m4",      3'd0, 32'd3,        32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFF4, 5};
        vecs[12] = '{"rsvd7",          3'd7, 32'h11111111, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFF4, 0};

        reset    = 1'b1;
        start    = 1'b0;
        md_op    = 3'd0;
        rs_data  = 32'd0;
        rt_data  = 32'd0;
        hilo_sel = 1'b0;
        md_in_D  = 1'b0;

        // Reset state
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall_D}, 32'd0);
        read_hilo(h, l);
        check("rst_hi", h, 32'd0);
        check("rst_lo", l, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven operations, issued back to back with md_in_D held high.
        md_in_D = 1'b1;
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            start   = 1'b1;
            md_op   = vecs[i].op;
            rs_data = vecs[i].rs;
            rt_data = vecs[i].rt;
            #1;
            check({vecs[i].name, "_stall_issue"}, {31'd0, stall_D},
                  {31'd0, (vecs[i].op <= 3'd3)});
            @(posedge clk);
            #1;
            start = 1'b0;
            cnt = 0;
            while (busy === 1'b1 && cnt < 64) begin
                if (cnt == 0) begin
                    read_hilo(h, l);
                    check({vecs[i].name, "_busy_hi"}, h, prev_hi);
                    check({vecs[i].name, "_busy_lo"}, l, prev_lo);
                end
                check({vecs[i].name, "_stall_busy"}, {31'd0, stall_D}, 32'd1);
                cnt++;
                @(posedge clk);
                #1;
            end
            check({vecs[i].name, "_cycles"}, cnt, vecs[i].cyc);
            check({vecs[i].name, "_stall_after"}, {31'd0, stall_D}, 32'd0);
            read_hilo(h, l);
            check({vecs[i].name, "_hi"}, h, vecs[i].hi);
            check({vecs[i].name, "_lo"}, l, vecs[i].lo);
            $display("[TB] vec %0d %s op=%0d rs=%h rt=%h -> hi=%h lo=%h busy_cycles=%0d",
                     i, vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, h, l, cnt);
            prev_hi = vecs[i].hi;
            prev_lo = vecs[i].lo;
        end
        md_in_D = 1'b0;

        // mthi while busy must be ignored; start during busy also stalls.
        issue(3'd0, 32'd2, 32'd3);
        check("mthi_busy_pre", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start   = 1'b1;
        md_op   = 3'd4;
        rs_data = 32'hDEADBEEF;
        md_in_D = 1'b1;
        #1;
        check("mthi_busy_stall", {31'd0, stall_D}, 32'd1);
        @(posedge clk);
        #1;
        start   = 1'b0;
        md_in_D = 1'b0;
        wait_idle("mthi_busy", cnt);
        check("mthi_busy_cycles", cnt, 4);
        read_hilo(h, l);
        check("mthi_busy_hi", h, 32'd0);
        check("mthi_busy_lo", l, 32'd6);
        $display("[TB] seq mthi_during_busy hi=%h lo=%h", h, l);

        // Back-to-back: second mult issued in the cycle busy falls.
        issue(3'd1, 32'd5, 32'd7);
        wait_idle("b2b_first", cnt);
        check("b2b_first_cycles", cnt, 5);
        issue(3'd0, 32'd100, 32'hFFFFFFFF);
        check("b2b_second_busy", {31'd0, busy}, 32'd1);
        wait_idle("b2b_second", cnt);
        check("b2b_second_cycles", cnt, 5);
        read_hilo(h, l);
        check("b2b_hi", h, 32'hFFFFFFFF);
        check("b2b_lo", l, 32'hFFFFFF9C);
        $display("[TB] seq back_to_back hi=%h lo=%h", h, l);

        // Reset in the 3rd busy cycle of a div.
        issue(3'd3, 32'd1000, 32'd3);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("rstmid_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        read_hilo(h, l);
        check("rstmid_hi", h, 32'd0);
        check("rstmid_lo", l, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            check("rstmid_hold_busy", {31'd0, busy}, 32'd0);
            read_hilo(h, l);
            check("rstmid_hold_hilo", h | l, 32'd0);
        end
        $display("[TB] seq reset_mid_div hi=%h lo=%h", h, l);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
